// File: rtl/cam_power_seq.sv
// Camera power-up sequencer: qualifies PLL lock, steps the sensor through
// power-down and reset hold times, starts the SCCB init block and supervises
// it with a timeout and bounded retries. Runs in the camera clock domain.
module cam_power_seq #(
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int PWDN_CYC         = 25000,
  parameter int RST_CYC          = 25000,
  parameter int POST_RST_CYC     = 500000,
  parameter int INIT_TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       init_done,
  input  logic       init_err,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       init_start,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state_o,
  output logic [1:0] retry_o
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_PWDN      = 3'd1,
    S_RST       = 3'd2,
    S_POST      = 3'd3,
    S_INIT      = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_READY     = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  // Timer terminal counts: a timed state of N cycles exits when timer == N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(INIT_TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d;
  logic             cam_pwdn_q, cam_pwdn_d;
  logic             cam_rst_n_q, cam_rst_n_d;
  logic             init_start_q, init_start_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             attempt_failed;

  // Next-state, timer and retry logic; outputs decoded from the next state so
  // the registered pins line up with the registered state.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + 1'b1;
    retry_d        = retry_q;
    attempt_failed = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        if (!pll_lock) begin
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          state_d = S_PWDN;
          timer_d = '0;
        end
      end
      S_PWDN: begin
        if (timer_q == PWDN_LAST) begin
          state_d = S_RST;
          timer_d = '0;
        end
      end
      S_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = S_POST;
          timer_d = '0;
        end
      end
      S_POST: begin
        if (timer_q == POST_LAST) begin
          state_d = S_INIT;
          timer_d = '0;
        end
      end
      S_INIT: begin
        state_d = S_WAIT_DONE;
        timer_d = '0;
      end
      S_WAIT_DONE: begin
        // An error beats a simultaneous done; a done on the last cycle still counts.
        if (init_err || (!init_done && timer_q == TO_LAST)) begin
          attempt_failed = 1'b1;
        end else if (init_done) begin
          state_d = S_READY;
          timer_d = '0;
        end
      end
      S_READY: timer_d = '0;
      S_FAIL:  timer_d = '0;
      default: begin
        state_d = S_WAIT_LOCK;
        timer_d = '0;
      end
    endcase

    if (attempt_failed) begin
      timer_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = S_PWDN;
      end else begin
        state_d = S_FAIL;
      end
    end

    // Losing lock restarts everything, except out of FAIL which only rst clears.
    if (!pll_lock && state_q != S_WAIT_LOCK && state_q != S_FAIL) begin
      state_d = S_WAIT_LOCK;
      timer_d = '0;
      retry_d = '0;
    end

    cam_pwdn_d   = (state_d == S_WAIT_LOCK) || (state_d == S_PWDN) || (state_d == S_FAIL);
    cam_rst_n_d  = (state_d == S_POST) || (state_d == S_INIT) ||
                   (state_d == S_WAIT_DONE) || (state_d == S_READY);
    init_start_d = (state_d == S_INIT);
    ready_d      = (state_d == S_READY);
    fail_d       = (state_d == S_FAIL);
  end

  // State, timer, retry counter and output pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_LOCK;
      timer_q      <= '0;
      retry_q      <= '0;
      cam_pwdn_q   <= 1'b1;
      cam_rst_n_q  <= 1'b0;
      init_start_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cam_pwdn_q   <= cam_pwdn_d;
      cam_rst_n_q  <= cam_rst_n_d;
      init_start_q <= init_start_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign cam_pwdn   = cam_pwdn_q;
  assign cam_rst_n  = cam_rst_n_q;
  assign init_start = init_start_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign state_o    = state_q;
  assign retry_o    = retry_q;

endmodule
